// File: rtl/cldn8_timer.sv
// Cascadable down-counting timer with IDLE/RUN/DONE control and a combinational borrow-out.
// Define CLDN8_AUTORELOAD_EN to reload from the last loaded value on terminal borrow instead of stopping.
module cldn8_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             bin,
  output logic [WIDTH-1:0] cnt,
  output logic             bout,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tick;

`ifdef CLDN8_AUTORELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  assign tick = (state_q == S_RUN) && en && bin;
  assign bout = tick && (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
`ifdef CLDN8_AUTORELOAD_EN
    reload_d = reload_q;
`endif
    if (clr) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (load) begin
      state_d = S_RUN;
      cnt_d   = load_val;
`ifdef CLDN8_AUTORELOAD_EN
      reload_d = load_val;
`endif
    end else begin
      case (state_q)
        S_RUN: begin
          if (tick) begin
            if (cnt_q != '0) begin
              cnt_d = cnt_q - WIDTH'(1);
            end else begin
              // Terminal borrow: the done pulse is registered, so it shows one cycle later.
              done_d = 1'b1;
`ifdef CLDN8_AUTORELOAD_EN
              cnt_d = reload_q;
`else
              state_d = S_DONE;
`endif
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        S_IDLE:  state_d = S_IDLE;
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    busy_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef CLDN8_AUTORELOAD_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) reload_q <= '0;
    else     reload_q <= reload_d;
  end
`endif

  assign cnt  = cnt_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_cldn8_timer.sv
// Bench for cldn8_timer (default build): directed scenarios plus a randomized run against
// a behavioural model of the timer's countdown rules.
module tb_cldn8_timer;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, clr, load, en, bin;
  logic [W-1:0] load_val;
  logic [W-1:0] cnt;
  logic         bout, busy, done;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: whether the timer is armed, its remaining count, and a pending done.
  bit m_armed;
  int m_cnt;
  bit m_done;
  bit exp_bout;
  logic obs_bout;

  cldn8_timer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .bin(bin), .cnt(cnt), .bout(bout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_armed = 1'b0;
    m_cnt   = 0;
    m_done  = 1'b0;
  endtask

  // One clock: drive inputs after the falling edge, sample bout mid-cycle, apply the
  // rising edge and advance the model, leaving outputs settled for the caller to check.
  task automatic cycle(input bit c, input bit l, input int lv, input bit e, input bit b);
    bit nxt_done;
    @(negedge clk);
    clr = c; load = l; load_val = W'(lv); en = e; bin = b;
    #1;
    obs_bout = bout;
    exp_bout = m_armed && e && b && (m_cnt == 0);
    @(posedge clk);
    #1;
    nxt_done = 1'b0;
    if (c) begin
      m_armed = 1'b0; m_cnt = 0;
    end else if (l) begin
      m_armed = 1'b1; m_cnt = lv;
    end else if (m_armed && e && b) begin
      if (m_cnt > 0) m_cnt = m_cnt - 1;
      else begin m_armed = 1'b0; nxt_done = 1'b1; end
    end
    m_done = nxt_done;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 0; load = 0; load_val = '0; en = 0; bin = 0;
    model_reset();
    #12;
    n_cmp++; if (cnt !== '0)  begin n_err++; $display("FAIL reset_cnt: got %0d expected 0", cnt); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
    n_cmp++; if (bout !== 1'b0) begin n_err++; $display("FAIL reset_bout: got %b expected 0", bout); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_countdown();
    // Load on the first edge after reset release.
    cycle(0, 1, 3, 0, 0);
    n_cmp++; if (cnt !== 8'd3 || busy !== 1'b1) begin n_err++; $display("FAIL cd_load: got cnt=%0d busy=%b expected cnt=3 busy=1", cnt, busy); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (cnt !== W'(3 - i)) begin n_err++; $display("FAIL cd_cnt%0d: got %0d expected %0d", i, cnt, 3 - i); end
      cycle(0, 0, 0, 1, 1);
      n_cmp++; if (obs_bout !== (i == 3)) begin n_err++; $display("FAIL cd_bout%0d: got %b expected %b", i, obs_bout, i == 3); end
      if (i < 3) begin
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL cd_early_done%0d: got %b expected 0", i, done); end
      end
    end
    n_cmp++; if (done !== 1'b1 || busy !== 1'b0 || cnt !== '0) begin n_err++; $display("FAIL cd_done: got done=%b busy=%b cnt=%0d expected 1 0 0", done, busy, cnt); end
    cycle(0, 0, 0, 1, 1);
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0 || obs_bout !== 1'b0) begin n_err++; $display("FAIL cd_idle: got done=%b busy=%b bout=%b expected 0 0 0", done, busy, obs_bout); end
  endtask

  task automatic test_cascade();
    bit bpat [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    int exp_c [4] = '{1, 1, 0, 0};
    cycle(0, 1, 2, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, 1, bpat[i]);
      n_cmp++; if (cnt !== W'(exp_c[i]) || obs_bout !== 1'b0) begin n_err++; $display("FAIL casc_%0d: got cnt=%0d bout=%b expected cnt=%0d bout=0", i, cnt, obs_bout, exp_c[i]); end
    end
    @(negedge clk);
    en = 1; bin = 0; #1;
    n_cmp++; if (bout !== 1'b0) begin n_err++; $display("FAIL casc_bout_low: got %b expected 0", bout); end
    bin = 1; #1;
    n_cmp++; if (bout !== 1'b1) begin n_err++; $display("FAIL casc_bout_high: got %b expected 1", bout); end
    bin = 0; #1;
    n_cmp++; if (bout !== 1'b0) begin n_err++; $display("FAIL casc_bout_fall: got %b expected 0", bout); end
    cycle(0, 0, 0, 1, 1);
    n_cmp++; if (obs_bout !== 1'b1) begin n_err++; $display("FAIL casc_term: got %b expected 1", obs_bout); end
    cycle(0, 0, 0, 0, 0);
  endtask

  task automatic test_priority();
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 5, 1, 1);
    n_cmp++; if (obs_bout !== 1'b1) begin n_err++; $display("FAIL prio_bout: got %b expected 1", obs_bout); end
    n_cmp++; if (cnt !== 8'd5 || busy !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL prio_reload: got cnt=%0d busy=%b done=%b expected 5 1 0", cnt, busy, done); end
    cycle(0, 0, 0, 0, 0);
    n_cmp++; if (done !== 1'b0 || cnt !== 8'd5) begin n_err++; $display("FAIL prio_nodone: got done=%b cnt=%0d expected 0 5", done, cnt); end
    cycle(1, 1, 9, 1, 1);
    n_cmp++; if (cnt !== '0 || busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL prio_clr: got cnt=%0d busy=%b done=%b expected 0 0 0", cnt, busy, done); end
  endtask

  task automatic test_async_reset();
    cycle(0, 1, 200, 0, 0);
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 1, 1);
    n_cmp++; if (cnt !== 8'd190) begin n_err++; $display("FAIL ar_pre: got %0d expected 190", cnt); end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (cnt !== '0 || busy !== 1'b0) begin n_err++; $display("FAIL ar_async: got cnt=%0d busy=%b expected 0 0", cnt, busy); end
    model_reset();
    @(posedge clk); #2 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 1, 1);
      n_cmp++; if (done !== 1'b0 || busy !== 1'b0 || cnt !== '0) begin n_err++; $display("FAIL ar_post%0d: got done=%b busy=%b cnt=%0d expected 0 0 0", i, done, busy, cnt); end
    end
  endtask

  task automatic test_zero_idle();
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 1, 1);
      n_cmp++; if (cnt !== '0 || obs_bout !== 1'b0) begin n_err++; $display("FAIL idle_%0d: got cnt=%0d bout=%b expected 0 0", i, cnt, obs_bout); end
    end
    cycle(0, 1, 0, 1, 1);
    cycle(0, 0, 0, 1, 1);
    n_cmp++; if (obs_bout !== 1'b1) begin n_err++; $display("FAIL zero_bout: got %b expected 1", obs_bout); end
    n_cmp++; if (done !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL zero_done: got done=%b busy=%b expected 1 0", done, busy); end
    cycle(0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bit c, l, e, b;
      int lv;
      c  = ($urandom_range(0, 31) == 0);
      l  = ($urandom_range(0, 9) == 0);
      e  = ($urandom_range(0, 3) != 0);
      b  = ($urandom_range(0, 3) != 0);
      lv = $urandom_range(0, 6);
      cycle(c, l, lv, e, b);
      n_cmp++;
      if (obs_bout !== exp_bout || cnt !== W'(m_cnt) || busy !== m_armed || done !== m_done) begin
        n_err++;
        $display("FAIL rand_%0d: got bout=%b cnt=%0d busy=%b done=%b expected bout=%b cnt=%0d busy=%b done=%b",
                 i, obs_bout, cnt, busy, done, exp_bout, m_cnt, m_armed, m_done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_cascade();
    test_priority();
    test_async_reset();
    test_zero_idle();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cldn8_timer.md
CLDN8_TIMER -- requirements
Module: cldn8_timer

Interface
REQ-001 Parameter WIDTH, default 8, sets the counter and load-data width in bits (legal range 2..16).
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 clr  input  1  synchronous clear to IDLE with count 0.
REQ-005 load  input  1  synchronous load of load_val; arms the timer.
REQ-006 load_val  input  WIDTH  start value, captured when load=1.
REQ-007 en  input  1  count enable.
REQ-008 bin  input  1  borrow-in (cascade enable); tie to 1 when the timer is not cascaded.
REQ-009 cnt  output  WIDTH  registered current count.
REQ-010 bout  output  1  combinational borrow-out; drives bin of the next stage.
REQ-011 busy  output  1  registered; high while state is RUN.
REQ-012 done  output  1  registered one-cycle pulse on terminal borrow.

Function
REQ-013 The block SHALL be a synchronous down-counter with states IDLE, RUN and DONE, encoded in registered state.
REQ-014 Update priority SHALL be, from highest to lowest: rst, clr, load, count.
REQ-015 clr=1: next state IDLE, cnt=0, done=0, and the reload register is unchanged.
REQ-016 load=1 with clr=0, in any state: cnt=load_val, reload register=load_val, next state RUN, done=0.
REQ-017 In RUN, a cycle with en=1 and bin=1 SHALL be a "tick"; with en=0 or bin=0, cnt and state SHALL hold.
REQ-018 On a tick with cnt!=0, cnt SHALL become cnt-1.
REQ-019 On a tick with cnt==0 (terminal borrow): next state DONE, cnt stays 0, and done=1 in the following cycle.
REQ-020 bout SHALL equal (state==RUN) & en & bin & (cnt==0), with zero-cycle latency from en/bin to bout.
REQ-021 DONE SHALL last exactly one cycle and then go to IDLE unless load or clr is asserted; done=1 only while in DONE.
REQ-022 In IDLE, ticks SHALL be ignored, and cnt and bout SHALL stay 0.
REQ-023 load_val=0 is legal: the first tick after the load produces an immediate terminal borrow.
REQ-024 Terminal delay SHALL be load_val+1 ticks from load to bout, for example load 3 -> bout on the 4th tick.
REQ-025 load asserted in the same cycle as a terminal-borrow tick SHALL win: RUN with the new value and no done pulse, while bout is still asserted that cycle.
REQ-026 cnt SHALL never wrap below 0 without an autoreload.

Reset
REQ-027 rst=1 SHALL immediately force state=IDLE, cnt=0, reload register=0, busy=0 and done=0, independent of clk.
REQ-028 rst asserted mid-RUN SHALL discard the count, and no done pulse SHALL follow deassertion.
REQ-029 After rst deassertion the block SHALL accept load on the first rising edge.

Configuration
REQ-030 Macro CLDN8_AUTORELOAD_EN SHALL control the autoreload feature.
REQ-031 With CLDN8_AUTORELOAD_EN defined, a terminal borrow SHALL reload cnt from the reload register and stay in RUN, with done pulsing for one cycle while busy stays high.
REQ-032 With CLDN8_AUTORELOAD_EN undefined, behaviour SHALL be exactly as REQ-019 and REQ-021; the reload register MAY be optimised away but SHALL not change ports.

Verification
REQ-033 Basic countdown: rst pulse, load_val=3 with load, then en=bin=1 held -> cnt 3,2,1,0; bout high on the 4th tick; done high for one cycle next; then IDLE with busy=0.
REQ-034 Cascade gating: load 2, en=1, bin toggled 1,0,1,0 -> cnt decrements only on bin=1 cycles; bout follows bin combinationally once cnt=0.
REQ-035 Priority: at cnt=0 tick, assert load=1 with load_val=5 -> bout=1 that cycle, next cnt=5 in RUN, no done pulse; clr together with load -> IDLE, cnt=0.
REQ-036 Async reset: load 200, tick 10 times (cnt=190), assert rst between clock edges -> cnt=0 and busy=0 before the next edge, and no done after release.
REQ-037 Zero load and idle: load_val=0 -> bout on the first tick; ticks in IDLE -> cnt stays 0 and bout stays 0.
REQ-038 Autoreload (macro defined): load 1, en=bin=1 for 6 ticks -> cnt 1,0,1,0,1,0, done pulses on ticks 2, 4 and 6, and busy stays 1 throughout.
